// File: rtl/shift_register_sequencer_pkg.sv
// Shared state encoding and counter-width helper for the shift register sequencer.
package shift_register_sequencer_pkg;

  localparam logic [1:0] IDLE_ENC  = 2'd0;
  localparam logic [1:0] SHIFT_ENC = 2'd1;
  localparam logic [1:0] DONE_ENC  = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = IDLE_ENC,
    SHIFT = SHIFT_ENC,
    DONE  = DONE_ENC
  } state_e;

  // A counter needs at least one bit even when it only ever holds 0.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/shift_register_sequencer_piso.sv
// Parallel-in/serial-out register: loads a word, shifts toward the head bit with zero fill.
module piso_shift_register #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] in,
  output logic             head
);

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;

  always_comb begin
    // NOTE: assign a default first so every path writes data_d; otherwise a latch is inferred.
    data_d = data_q;
    if (load) begin
      data_d = in;
    end else if (shift) begin
      data_d = MSB_FIRST ? {data_q[WIDTH-2:0], 1'b0} : {1'b0, data_q[WIDTH-1:1]};
    end
  end

  // NOTE: sequential state uses non-blocking assignment so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) data_q <= '0;
    else     data_q <= data_d;
  end

  assign head = MSB_FIRST ? data_q[WIDTH-1] : data_q[0];

endmodule

// File: rtl/shift_register_sequencer.sv
// Serializes WIDTH-bit words accepted over valid/ready, holding each bit CLKS_PER_BIT cycles.
module shift_register_sequencer
  import shift_register_sequencer_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 1,
  parameter bit MSB_FIRST    = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             abort,
  output logic             shift_out,
  output logic             shift_en,
  output logic             busy,
  output logic             done
);

  localparam int BIT_W = cnt_width(WIDTH);
  localparam int PER_W = cnt_width(CLKS_PER_BIT);

  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);
  localparam logic [PER_W-1:0] PER_LAST = PER_W'(CLKS_PER_BIT - 1);

  state_e           state_q, state_d;
  logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [PER_W-1:0] per_cnt_q, per_cnt_d;
  logic             load;
  logic             shift;
  logic             head;

  piso_shift_register #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_piso (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .shift (shift),
    .in    (in_data),
    .head  (head)
  );

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    per_cnt_d = per_cnt_q;
    load      = 1'b0;
    shift     = 1'b0;
    in_ready  = 1'b0;
    busy      = 1'b0;
    shift_out = 1'b0;
    shift_en  = 1'b0;
    done      = 1'b0;

    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid && !abort) begin
          load      = 1'b1;
          bit_cnt_d = '0;
          per_cnt_d = '0;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        busy      = 1'b1;
        shift_out = head;
        shift_en  = (per_cnt_q == '0);
        if (abort) begin
          bit_cnt_d = '0;
          per_cnt_d = '0;
          state_d   = IDLE;
        end else if (per_cnt_q == PER_LAST) begin
          shift     = 1'b1;
          per_cnt_d = '0;
          // Last bit: return the bit counter to 0 instead of stepping past WIDTH-1.
          if (bit_cnt_q == BIT_LAST) begin
            bit_cnt_d = '0;
            state_d   = DONE;
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
          end
        end else begin
          per_cnt_d = per_cnt_q + PER_W'(1);
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Outputs are forced low for the whole cycle in which reset is asserted.
    if (rst) begin
      in_ready  = 1'b0;
      busy      = 1'b0;
      shift_out = 1'b0;
      shift_en  = 1'b0;
      done      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      per_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      per_cnt_q <= per_cnt_d;
    end
  end

endmodule
